div_ctrl_rv32m: RTL and testbench

DIV_CTRL_RV32M -- requirements
Module: div_ctrl_rv32m

---
 rtl/div_ctrl_rv32m.sv | 158 +++++++++++++++
 tb/tb_div_ctrl_rv32m.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl_rv32m.sv
// div_ctrl_rv32m: control wrapper that runs RV32M DIV/DIVU/REM/REMU on an
// external unsigned iterative divider core.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid && ready are both 1. The request side is accepted only in IDLE with
// no flush. The response side holds valid, data and tag stable until ready.
//
// Ports
//   clk, rstLow              clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake
//   i_funct3                 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_rs1, i_rs2             dividend, divisor
//   i_rd_tag                 destination tag, returned with the result
//   i_flush                  abort in-flight/pending operation
//   o_resp_valid/i_resp_ready, o_resp_data, o_resp_tag  result channel
//   o_core_a/o_core_b        unsigned core operands
//   o_core_start             one-cycle core start pulse (ISSUE only)
//   i_core_busy, i_core_q, i_core_r  core status and results
//   o_dbg_state              current FSM state
module div_ctrl_rv32m #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstLow,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_funct3,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_rd_tag,
  input  logic             i_flush,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [31:0]      o_resp_data,
  output logic [TAG_W-1:0] o_resp_tag,
  output logic [31:0]      o_core_a,
  output logic [31:0]      o_core_b,
  output logic             o_core_start,
  input  logic             i_core_busy,
  input  logic [31:0]      i_core_q,
  input  logic [31:0]      i_core_r,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    POST  = 3'd4,
    RESP  = 3'd5,
    DRAIN = 3'd6
  } state_t;

  state_t r_state, w_next;

  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_seen_busy;
  logic [31:0]      r_result;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_core_a;
  logic [31:0]      r_core_b;

  // Request decode. Encodings without funct3[2] set are run as unsigned.
  logic        w_signed;
  logic        w_is_rem;
  logic        w_rs1_neg;
  logic        w_rs2_neg;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic        w_div0;
  logic        w_ovf;
  logic        w_bypass;
  logic [31:0] w_bypass_data;
  logic        w_accept;

  assign w_signed  = i_funct3[2] & ~i_funct3[0];
  assign w_is_rem  = i_funct3[1];
  assign w_rs1_neg = w_signed & i_rs1[31];
  assign w_rs2_neg = w_signed & i_rs2[31];
  // Negating 0x80000000 wraps back to itself, which is the wanted magnitude.
  assign w_abs1    = w_rs1_neg ? (32'd0 - i_rs1) : i_rs1;
  assign w_abs2    = w_rs2_neg ? (32'd0 - i_rs2) : i_rs2;
  assign w_div0    = (i_rs2 == 32'd0);
  assign w_ovf     = w_signed && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
  assign w_bypass  = w_div0 | w_ovf;
  assign w_bypass_data = w_div0 ? (w_is_rem ? i_rs1 : 32'hFFFF_FFFF)
                                : (w_is_rem ? 32'd0 : 32'h8000_0000);

  // rstLow gates req_ready so every output is 0 while reset is held.
  assign o_req_ready  = rstLow && (r_state == IDLE) && !i_flush;
  assign w_accept     = i_req_valid && o_req_ready;
  assign o_core_start = (r_state == ISSUE);
  assign o_resp_valid = (r_state == RESP);
  assign o_resp_data  = r_result;
  assign o_resp_tag   = r_tag;
  assign o_core_a     = r_core_a;
  assign o_core_b     = r_core_b;
  assign o_dbg_state  = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = w_bypass ? RESP : ISSUE;
      ISSUE: w_next = i_flush ? DRAIN : ARM;
      ARM:   if (i_flush) w_next = DRAIN;
             else if (i_core_busy) w_next = RUN;
      RUN:   if (i_flush) w_next = DRAIN;
             else if (!i_core_busy) w_next = POST;
      POST:  w_next = i_flush ? IDLE : RESP;
      RESP:  if (i_flush || i_resp_ready) w_next = IDLE;
      // Core was started; wait for its busy pulse to finish, ignore result.
      DRAIN: if (r_seen_busy && !i_core_busy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      r_is_rem    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_seen_busy <= 1'b0;
      r_result    <= 32'd0;
      r_tag       <= '0;
      r_core_a    <= 32'd0;
      r_core_b    <= 32'd0;
    end else begin
      if (w_accept) begin
        r_is_rem <= w_is_rem;
        r_neg_q  <= w_rs1_neg ^ w_rs2_neg;
        r_neg_r  <= w_rs1_neg;
        r_tag    <= i_rd_tag;
        r_core_a <= w_abs1;
        r_core_b <= w_abs2;
        if (w_bypass) r_result <= w_bypass_data;
      end
      if (r_state == POST) begin
        if (r_is_rem) r_result <= r_neg_r ? (32'd0 - i_core_r) : i_core_r;
        else          r_result <= r_neg_q ? (32'd0 - i_core_q) : i_core_q;
      end
      // Entering DRAIN from RUN means busy was already seen high; from
      // ISSUE/ARM it may still be about to rise.
      if (r_state != DRAIN && w_next == DRAIN)
        r_seen_busy <= i_core_busy || (r_state == RUN);
      else if (r_state == DRAIN && i_core_busy)
        r_seen_busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_ctrl_rv32m.sv
module tb_div_ctrl_rv32m;

  localparam int TAG_W = 5;
  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic rstLow = 1'b0;
  always #5 clk = ~clk;

  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       funct3 = 3'b000;
  logic [31:0]      rs1 = 32'd0;
  logic [31:0]      rs2 = 32'd0;
  logic [TAG_W-1:0] rd_tag = '0;
  logic             flush = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      core_a, core_b;
  logic             core_start;
  logic             core_busy;
  logic [31:0]      core_q, core_r;
  logic [2:0]       dbg_state;

  div_ctrl_rv32m #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstLow(rstLow),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2), .i_rd_tag(rd_tag),
    .i_flush(flush),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_data(resp_data), .o_resp_tag(resp_tag),
    .o_core_a(core_a), .o_core_b(core_b), .o_core_start(core_start),
    .i_core_busy(core_busy), .i_core_q(core_q), .i_core_r(core_r),
    .o_dbg_state(dbg_state)
  );

  // Unsigned divider core model: busy rises on the start edge and stays
  // high for 33 cycles.
  logic [5:0] core_cnt;
  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      core_busy <= 1'b0;
      core_cnt  <= 6'd0;
      core_q    <= 32'd0;
      core_r    <= 32'd0;
    end else if (core_start) begin
      core_busy <= 1'b1;
      core_cnt  <= 6'd33;
      core_q    <= (core_b != 0) ? core_a / core_b : 32'hFFFF_FFFF;
      core_r    <= (core_b != 0) ? core_a % core_b : core_a;
    end else if (core_busy) begin
      core_cnt <= core_cnt - 6'd1;
      if (core_cnt == 6'd1) core_busy <= 1'b0;
    end
  end

  int start_cnt = 0;
  int start_while_busy = 0;
  always @(posedge clk) begin
    if (core_start) start_cnt <= start_cnt + 1;
    if (core_start && core_busy) start_while_busy <= start_while_busy + 1;
  end

  // scoreboard
  logic [31:0]      exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      F_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive one request, wait for the response, check latency, result, tag and
  // core usage, optionally hold backpressure, then complete the handshake.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp,
                       input int exp_lat, input int hold);
    int n;
    int s0;
    logic [31:0] ed;
    logic [TAG_W-1:0] et;
    chk("req_ready_before_op", {31'd0, req_ready}, 32'd1);
    funct3 = f; rs1 = a; rs2 = b; rd_tag = tag; req_valid = 1'b1;
    exp_q.push_back(exp);
    exp_tag_q.push_back(tag);
    s0 = start_cnt;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("resp_latency", n, exp_lat);
    chk("core_start_count", start_cnt - s0, (exp_lat == 0) ? 32'd0 : 32'd1);
    ed = exp_q.pop_front();
    et = exp_tag_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_data", resp_data, ed);
      chk("bp_tag", {27'd0, resp_tag}, {27'd0, et});
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_data", resp_data, ed);
    chk("resp_tag", {27'd0, resp_tag}, {27'd0, et});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_after_hs", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  {31'd0, req_ready}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_data"},  resp_data, 32'd0);
    chk({tag, "_resp_tag"},   {27'd0, resp_tag}, 32'd0);
    chk({tag, "_core_a"},     core_a, 32'd0);
    chk({tag, "_core_b"},     core_b, 32'd0);
    chk({tag, "_core_start"}, {31'd0, core_start}, 32'd0);
    chk({tag, "_state"},      {29'd0, dbg_state}, {29'd0, S_IDLE});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    logic [2:0] f;
    logic [31:0] a, b;

    // reset
    repeat (3) tick();
    chk_all_zero("reset");
    @(negedge clk);
    rstLow = 1'b1;
    #1;
    chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

    // core-path operations
    do_op(F_DIVU, 32'd100, 32'd7, 5'd3, 32'h0000_000E, 36, 0);
    do_op(F_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 36, 0);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 36, 0);
    do_op(F_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 36, 0);
    do_op(F_DIV, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 36, 0);
    do_op(F_REM, 32'h8000_0000, 32'd3, 5'd8, 32'hFFFF_FFFE, 36, 0);

    // bypass cases
    do_op(F_DIVU, 32'd1234, 32'd0, 5'd9, 32'hFFFF_FFFF, 0, 0);
    do_op(F_REM, 32'd5, 32'd0, 5'd10, 32'd5, 0, 0);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, 0);
    do_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0, 0);

    // backpressure
    do_op(F_DIVU, 32'd1000, 32'd33, 5'd13, 32'd30, 36, 10);
    do_op(F_REMU, 32'd77, 32'd0, 5'd14, 32'd77, 0, 10);

    // random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(4, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFFF;
      do_op(f, a, b, 5'($urandom_range(0, 31)), ref_op(f, a, b),
            ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 36, 0);
    end

    // flush in IDLE blocks acceptance
    s0 = start_cnt;
    flush = 1'b1;
    funct3 = F_DIVU; rs1 = 32'd50; rs2 = 32'd5; req_valid = 1'b1;
    #1;
    chk("idle_flush_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("idle_flush_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    tick();
    chk("idle_flush_no_start", start_cnt - s0, 32'd0);
    chk("idle_flush_no_resp", {31'd0, resp_valid}, 32'd0);

    // flush 5 cycles into RUN
    funct3 = F_DIVU; rs1 = 32'd1000; rs2 = 32'd3; rd_tag = 5'd20; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_to_drain", {29'd0, dbg_state}, {29'd0, S_DRAIN});
    n = 0;
    while (!req_ready && n < 100) begin
      chk("drain_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("drain_core_start", {31'd0, core_start}, 32'd0);
      tick();
      n++;
    end
    chk("drain_cycles", n, 32'd27);
    chk("drain_core_idle", {31'd0, core_busy}, 32'd0);
    do_op(F_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 36, 0);

    // reset during RUN
    funct3 = F_DIV; rs1 = 32'd500; rs2 = 32'd7; rd_tag = 5'd22; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    rstLow = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick();
    chk_all_zero("mid_reset_held");
    @(negedge clk);
    rstLow = 1'b1;
    n = 0;
    repeat (40) begin
      tick();
      if (resp_valid) n++;
    end
    chk("no_resp_after_reset", n, 32'd0);
    do_op(F_DIV, 32'hFFFF_FF9C, 32'd7, 5'd23, 32'hFFFF_FFF2, 36, 0);

    chk("start_while_busy", start_while_busy, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
